pulse_divider: RTL and testbench
================================

PULSE_DIVIDER -- requirements
Module: pulse_divider

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of divisor, duty and phase counter.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the pulse counter.
REQ-003 Parameter DIV_RESET, default 4, SHALL be the divisor loaded at reset; it SHALL be nonzero.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-006 enable  in  1  SHALL allow running when high and force IDLE when low.
REQ-007 mode  in  2  SHALL select the output mode: 00 PULSE, 01 SQUARE, 10 PWM, 11 HOLD.
REQ-008 div_in  in  WIDTH  SHALL carry the new divisor D.
REQ-009 div_load  in  1  SHALL be a one-cycle strobe requesting capture of div_in.
REQ-010 duty  in  WIDTH  SHALL carry the PWM high-time in cycles.
REQ-011 pulse  out  1  SHALL be the registered generated waveform.
REQ-012 tick  out  1  SHALL be a registered one-cycle strobe at each period boundary.
REQ-013 div_cur  out  WIDTH  SHALL show the divisor in effect.
REQ-014 pulse_count  out  CNT_W  SHALL count ticks issued since reset.
REQ-015 load_pending  out  1  SHALL be high while a captured divisor awaits a boundary.

Function
REQ-016 States SHALL be IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0, both at the next edge.
REQ-017 In IDLE, phase counter, pulse and tick SHALL be 0.
REQ-018 On entering RUN, phase SHALL start at 0 and the first boundary SHALL occur D cycles after the edge on which enable was sampled high.
REQ-019 In RUN, with mode not HOLD, phase SHALL count 0..D-1; at phase=D-1 it SHALL return to 0 and tick SHALL be 1 for the following cycle.
REQ-020 D=0 SHALL behave as D=1, giving a tick every cycle.
REQ-021 PULSE mode: pulse SHALL equal tick.
REQ-022 SQUARE mode: pulse SHALL toggle at each boundary, giving period 2D and 50% duty.
REQ-023 PWM mode: pulse SHALL be high in the cycle after phase<duty is sampled; if duty>=D, pulse SHALL stay high; if duty=0, pulse SHALL stay low.
REQ-024 HOLD mode: phase, pulse and pulse_count SHALL freeze at their current values, tick SHALL be 0, and the state SHALL stay RUN.
REQ-025 A mode change in RUN SHALL NOT reset phase; the new mode SHALL apply from the next edge.
REQ-026 div_load in IDLE SHALL update div_cur at the next edge and leave load_pending at 0.
REQ-027 div_load in RUN SHALL capture div_in and set load_pending; div_cur SHALL update at the next boundary, and load_pending SHALL clear at that same boundary.
REQ-028 If div_load coincides with a boundary, the new divisor SHALL govern the period starting at that boundary.
REQ-029 A second div_load while pending SHALL overwrite the captured value; the last value wins.
REQ-030 pulse_count SHALL increment on every tick and wrap from all-ones to 0.
REQ-031 If enable drops while load_pending=1, the pending divisor SHALL be applied to div_cur on the IDLE entry edge.

Reset
REQ-032 On a clock edge with reset=0, outputs SHALL become: state IDLE, phase 0, pulse 0, tick 0, pulse_count 0, load_pending 0, div_cur DIV_RESET.
REQ-033 Reset SHALL override enable, div_load and mode, including mid-period and mid-pending-load.

Structure
REQ-034 Shared package pulse_pkg SHALL hold the mode encodings (MODE_PULSE, MODE_SQUARE, MODE_PWM, MODE_HOLD) and the state encoding (ST_IDLE, ST_RUN).
REQ-035 Sub-module pulse_timebase SHALL contain the phase counter, boundary detect and divisor reload logic.
REQ-036 pulse_divider SHALL contain the FSM, mode output logic and pulse_count.

Verification
REQ-037 Reset, enable=1, mode=00, D=4 -> tick/pulse high 1 of every 4 cycles; pulse_count=5 after 20 cycles.
REQ-038 mode=01, D=4 -> pulse period 8 cycles, high 4 / low 4.
REQ-039 mode=10, D=8, duty=3 -> pulse high 3 of 8 cycles; duty=0 -> always low; duty=9 -> always high.
REQ-040 RUN with D=4, div_load D=2 at phase 1 -> load_pending high until the next boundary, then ticks every 2 cycles; div_load on a boundary cycle -> the new period applies immediately.
REQ-041 mode=11 for 5 cycles mid-period -> phase and pulse_count unchanged, tick=0; on return to 00 -> counting resumes from the frozen phase.
REQ-042 reset=0 asserted mid-period with load pending -> next edge gives all outputs 0, div_cur=4, load_pending=0; D=0 -> tick every cycle.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared encodings for the pulse divider: output modes and FSM states.
package pulse_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PULSE  = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_timebase.sv
// Phase counter, period boundary detect and divisor reload for pulse_divider.
// Ports:
//   clock, reset    : clock and synchronous active-low reset
//   active          : RUN and enabled this cycle; low parks the phase at 0
//   hold            : freeze phase (HOLD mode)
//   div_in/div_load : new divisor and its one-cycle capture strobe
//   phase           : current position inside the period
//   boundary_c      : combinational, high in the last cycle of a period
//   div_cur         : divisor in effect
//   load_pending    : a captured divisor waits for the next boundary
module pulse_timebase
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             hold,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] phase,
  output logic             boundary_c,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pending
);

  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] div_held;
  logic [WIDTH-1:0] div_next;

  // A zero divisor behaves as one: a boundary every cycle.
  assign div_eff = (div_cur == '0) ? WIDTH'(1) : div_cur;

  assign boundary_c = active && !hold && (phase >= div_eff - WIDTH'(1));

  // Divisor adopted at a reload point; a strobe in that same cycle wins
  // over an older captured value.
  assign div_next = div_load ? div_in : (load_pending ? div_held : div_cur);

  // Phase and divisor state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase        <= '0;
      div_cur      <= WIDTH'(DIV_RESET);
      div_held     <= '0;
      load_pending <= 1'b0;
    end else if (!active) begin
      // Idle or leaving RUN: nothing to wait for, commit immediately.
      phase        <= '0;
      div_cur      <= div_next;
      load_pending <= 1'b0;
    end else begin
      if (!hold) begin
        phase <= boundary_c ? '0 : phase + WIDTH'(1);
      end
      if (boundary_c) begin
        div_cur      <= div_next;
        load_pending <= 1'b0;
      end else if (div_load) begin
        div_held     <= div_in;
        load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_divider.sv
// Programmable pulse divider: IDLE/RUN control, four output waveforms
// (pulse, square, PWM, hold) and a running count of issued ticks.
// Ports:
//   clock, reset    : clock and synchronous active-low reset
//   enable          : run when high, return to IDLE when low
//   mode            : 00 pulse, 01 square, 10 PWM, 11 hold
//   div_in/div_load : new divisor and its one-cycle load strobe
//   duty            : PWM high time in cycles
//   pulse, tick     : registered waveform and period-boundary strobe
//   div_cur         : divisor in effect
//   pulse_count     : ticks issued since reset, wrapping
//   load_pending    : captured divisor waiting for a boundary
module pulse_divider
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic [WIDTH-1:0] duty,
  output logic             pulse,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic [CNT_W-1:0] pulse_count,
  output logic             load_pending
);

  state_t           state;
  mode_t            mode_sel;
  logic             active_c;
  logic             hold_c;
  logic             boundary_c;
  logic [WIDTH-1:0] phase;

  assign mode_sel = mode_t'(mode);
  assign active_c = (state == ST_RUN) && enable;
  assign hold_c   = (mode_sel == MODE_HOLD);

  pulse_timebase #(
    .WIDTH     (WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_timebase (
    .clock        (clock),
    .reset        (reset),
    .active       (active_c),
    .hold         (hold_c),
    .div_in       (div_in),
    .div_load     (div_load),
    .phase        (phase),
    .boundary_c   (boundary_c),
    .div_cur      (div_cur),
    .load_pending (load_pending)
  );

  // Control FSM, waveform generation and tick counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pulse       <= 1'b0;
      tick        <= 1'b0;
      pulse_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pulse <= 1'b0;
          tick  <= 1'b0;
          if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
            pulse <= 1'b0;
            tick  <= 1'b0;
          end else begin
            // boundary_c is already suppressed in HOLD, so tick and
            // pulse_count freeze there without extra gating.
            tick <= boundary_c;
            if (boundary_c) begin
              pulse_count <= pulse_count + CNT_W'(1);
            end
            case (mode_sel)
              MODE_PULSE:  pulse <= boundary_c;
              MODE_SQUARE: pulse <= boundary_c ? ~pulse : pulse;
              MODE_PWM:    pulse <= (phase < duty);
              MODE_HOLD:   pulse <= pulse;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_divider.sv
module tb_pulse_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  div_in = 8'd0;
  logic        div_load = 1'b0;
  logic [7:0]  duty = 8'd0;
  logic        pulse;
  logic        tick;
  logic [7:0]  div_cur;
  logic [15:0] pulse_count;
  logic        load_pending;

  int checks = 0;
  int errors = 0;

  pulse_divider #(.WIDTH(8), .CNT_W(16), .DIV_RESET(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .div_in       (div_in),
    .div_load     (div_load),
    .duty         (duty),
    .pulse        (pulse),
    .tick         (tick),
    .div_cur      (div_cur),
    .pulse_count  (pulse_count),
    .load_pending (load_pending)
  );

  always #5 clock = ~clock;

  wire [26:0] obs = {pulse, tick, div_cur, pulse_count, load_pending};

  // Reference model: position inside the current period, the divisor in
  // use and a list of divisors requested while running (last one wins).
  bit         m_run;
  int         m_pos;
  logic [7:0] m_div;
  logic [7:0] m_q[$];
  logic       m_tick;
  logic       m_pulse;
  logic [15:0] m_cnt;

  function automatic logic [26:0] exp_vec();
    return {m_pulse, m_tick, m_div, m_cnt, (m_q.size() != 0)};
  endfunction

  task automatic model_edge();
    int  deff;
    int  old_pos;
    bit  bnd;
    if (!reset) begin
      m_run = 0; m_pos = 0; m_div = 8'd4; m_q.delete();
      m_tick = 0; m_pulse = 0; m_cnt = 16'd0;
    end else if (!m_run || !enable) begin
      if (div_load) m_div = div_in;
      else if (m_q.size() != 0) m_div = m_q[$];
      m_q.delete();
      m_pos = 0; m_tick = 0; m_pulse = 0;
      m_run = !m_run && enable;
    end else if (mode == 2'b11) begin
      m_tick = 0;
      if (div_load) m_q.push_back(div_in);
    end else begin
      deff = (m_div == 8'd0) ? 1 : int'(m_div);
      old_pos = m_pos;
      bnd = (m_pos == deff - 1);
      m_tick = bnd;
      if (bnd) begin
        m_cnt = m_cnt + 16'd1;
        m_pos = 0;
        if (div_load) m_div = div_in;
        else if (m_q.size() != 0) m_div = m_q[$];
        m_q.delete();
      end else begin
        m_pos = m_pos + 1;
        if (div_load) m_q.push_back(div_in);
      end
      case (mode)
        2'b00:   m_pulse = bnd;
        2'b01:   m_pulse = bnd ? !m_pulse : m_pulse;
        default: m_pulse = (old_pos < int'(duty));
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; enable = 1'b0; mode = 2'b00; div_load = 1'b0;
    div_in = 8'd0; duty = 8'd0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs !== 27'({1'b0, 1'b0, 8'd4, 16'd0, 1'b0})) begin
      errors++;
      $display("FAIL reset_values got=%h want=%h", obs, 27'({1'b0, 1'b0, 8'd4, 16'd0, 1'b0}));
    end
  endtask

  task automatic test_pulse_mode();
    int nt = 0;
    apply_reset();
    enable = 1'b1; mode = 2'b00;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) nt++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pulse_mode cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pulse_count !== 16'd5 || nt != 5) begin
      errors++;
      $display("FAIL pulse_count20 got=%0d ticks=%0d want=5", pulse_count, nt);
    end
  endtask

  task automatic test_square();
    int nh = 0;
    apply_reset();
    div_in = 8'd4; div_load = 1'b1;
    step();
    div_load = 1'b0; enable = 1'b1; mode = 2'b01;
    step();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i >= 8 && pulse) nh++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL square cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (nh != 16) begin
      errors++;
      $display("FAIL square_duty high=%0d want=16", nh);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties[3] = '{8'd3, 8'd0, 8'd9};
    int         want[3]   = '{6, 0, 16};
    int         nh;
    apply_reset();
    div_in = 8'd8; div_load = 1'b1;
    step();
    div_load = 1'b0; enable = 1'b1; mode = 2'b10;
    step();
    for (int k = 0; k < 3; k++) begin
      duty = duties[k];
      step();
      nh = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (pulse) nh++;
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL pwm duty=%0d cyc=%0d got=%h want=%h", duty, i, obs, exp_vec());
        end
      end
      checks++;
      if (nh != want[k]) begin
        errors++;
        $display("FAIL pwm_high duty=%0d got=%0d want=%0d", duty, nh, want[k]);
      end
    end
  endtask

  task automatic test_div_load();
    int n;
    apply_reset();
    enable = 1'b1; mode = 2'b00;
    step();
    step();
    div_in = 8'd2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1 || div_cur !== 8'd4) begin
      errors++;
      $display("FAIL load_pending_set got=%b/%0d want=1/4", load_pending, div_cur);
    end
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    checks++;
    if (n != 2 || div_cur !== 8'd2 || load_pending !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL load_apply got=%0d/%0d/%b want=2/2/0", n, div_cur, load_pending);
    end
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL period2 got=%0d want=2", n);
    end
    step();
    div_in = 8'd3; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (tick !== 1'b1 || div_cur !== 8'd3 || load_pending !== 1'b0) begin
      errors++;
      $display("FAIL boundary_load got=%b/%0d/%b want=1/3/0", tick, div_cur, load_pending);
    end
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    checks++;
    if (n != 3 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL period3 got=%0d want=3", n);
    end
  endtask

  task automatic test_hold();
    logic [15:0] cnt0;
    int          n;
    apply_reset();
    enable = 1'b1; mode = 2'b00;
    step();
    step();
    cnt0 = pulse_count;
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || pulse_count !== cnt0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    mode = 2'b00;
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    checks++;
    if (n != 3 || pulse_count !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL hold_resume got=%0d cnt=%0d want=3 cnt=%0d", n, pulse_count, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    enable = 1'b1; mode = 2'b01;
    for (int i = 0; i < 6; i++) step();
    div_in = 8'd7; div_load = 1'b1;
    step();
    div_load = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (obs !== 27'({1'b0, 1'b0, 8'd4, 16'd0, 1'b0}) || obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_load got=%h want=%h", obs, 27'({1'b0, 1'b0, 8'd4, 16'd0, 1'b0}));
    end
    reset = 1'b1;
  endtask

  task automatic test_div_zero();
    int nt = 0;
    apply_reset();
    div_in = 8'd0; div_load = 1'b1;
    step();
    div_load = 1'b0; enable = 1'b1; mode = 2'b00;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick) nt++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL div_zero cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (nt != 10) begin
      errors++;
      $display("FAIL div_zero_ticks got=%0d want=10", nt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) != 0);
      enable   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      div_load = ($urandom_range(0, 7) == 0);
      div_in   = 8'($urandom_range(0, 7));
      duty     = 8'($urandom_range(0, 9));
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pulse_mode();
    test_square();
    test_pwm();
    test_div_load();
    test_hold();
    test_reset_mid_load();
    test_div_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
